multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control unit. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It sits between the instruction register and the shared datapath (PC, memory port, register file, ALU). It also adds a memory-ready handshake, a wait-timeout, illegal-opcode flagging and a retired-instruction counter.

## Interface
- OPCODE_W, 6, opcode field width; supported opcodes occupy the low 6 bits, upper bits must be 0.
- TIMEOUT, 16, consecutive cycles of mem_ready low before bus_error; 0 disables the timeout.
- CNT_W, 32, width of instr_count.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode from the instruction register; sampled in DECODE.
- mem_ready  in  1  memory completes the current read/write in this cycle.
- pc_write, pc_write_cond, i_or_d, ir_write  out  1 each  PC write, branch-qualified PC write, address select (1 = ALU out), IR load.
- mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 and.
- pc_source  out  2  00 ALU result, 01 ALU out register, 10 jump target.
- state  out  4  current state encoding.
- illegal_op, bus_error  out  1 each  one-cycle registered error pulses.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11. Encodings 12-15 are unused and return to FETCH.
- Every control output is 0 unless listed for the current state.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready, combinationally.
  - Stay in FETCH while mem_ready=0.
  - Go to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 or 110000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 001000 or 001100 -> IMM_EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other value -> FETCH, and illegal_op is set
- EXECUTE: alu_src_a=1, alu_op=10. alu_src_b=00 for opcode 000000, 10 for opcode 110000 (shift). -> ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1. -> FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10. alu_op=00 for addi, 11 for andi. -> IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0. -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. -> MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. -> FETCH.
- JUMP: pc_write=1, pc_source=10. -> FETCH.
- The opcode is latched in DECODE. Later states use the latched copy, not the live input.
- Wait counter:
  - Counts cycles in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on any state change or when mem_ready=1.
  - When TIMEOUT≠0 and the count reaches TIMEOUT: the state goes to FETCH and bus_error is set. No IR or PC write occurs and the instruction does not retire.
- instr_count increments by 1 on each transition into FETCH from ALU_WB, IMM_WB, MEM_WB, MEM_WRITE (completed), BRANCH or JUMP. There is no increment on the illegal or timeout paths.

## Timing
- Reset (reset_n low) asynchronously forces:
  - state=FETCH, instr_count=0, wait counter=0, illegal_op=0, bus_error=0, latched opcode=0.
  - All control outputs to 0, gated by reset_n while it is low.
  - First fetch mem_read appears in the first cycle reset_n is high.
- Reset mid-instruction abandons the instruction with no partial writes after reset assertion.
- Minimum cycles with mem_ready held high: lw 5; sw, R-type, shift, addi, andi 4; beq, j 3.
  - Each memory-wait cycle adds 1.
- illegal_op and bus_error are high for exactly the one cycle after detection, which is the first FETCH cycle.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- If mem_ready=1 arrives in the same cycle the count reaches TIMEOUT, completion wins and there is no bus_error.

## Test plan
- Reset release with mem_ready=1, opcode=000000 -> state sequence 0,1,6,7,0 with reg_dst=reg_write=1 in state 7; instr_count=1.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> 8 cycles total; mem_read and i_or_d held for the 4 MEM_READ cycles; MEM_WB has mem_to_reg=1.
- Opcode 111111 -> DECODE goes to FETCH; illegal_op pulses 1 cycle; instr_count unchanged.
- TIMEOUT=4, sw with mem_ready stuck low -> MEM_WRITE for 4 cycles, then FETCH; bus_error 1 cycle; no retire. Repeat with mem_ready rising on cycle 4 -> normal completion, no bus_error.
- beq then j -> BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01; JUMP shows pc_write=1, pc_source=10; instr_count +2.
- CNT_W=2: retire 5 instructions -> instr_count reads 1. reset_n pulsed low in MEM_ADDR -> all outputs 0 immediately and state=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore sequencer for fetch/decode/execute/memory/write-back
// with memory-ready handshake, wait timeout, illegal-opcode flag and retired-instruction counter.
module multicycle_control #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          state,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_SHIFT = OPCODE_W'(6'b110000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11
  } state_t;

  state_t              state_q;
  logic [OPCODE_W-1:0] opcode_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_hit;

  // A ready memory always wins over an expiring wait count.
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

  assign state = state_q;

  // Sequencer: state, latched opcode, wait counter, error pulses, retire counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      opcode_q    <= '0;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
      wait_cnt   <= '0;
      case (state_q)
        S_FETCH: begin
          if (mem_ready)        state_q <= S_DECODE;
          else if (timeout_hit) bus_error <= 1'b1;
          else                  wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_DECODE: begin
          opcode_q <= opcode;
          case (opcode)
            OP_RTYPE, OP_SHIFT: state_q <= S_EXECUTE;
            OP_LW, OP_SW:       state_q <= S_MEM_ADDR;
            OP_ADDI, OP_ANDI:   state_q <= S_IMM_EXEC;
            OP_BEQ:             state_q <= S_BRANCH;
            OP_J:               state_q <= S_JUMP;
            default: begin
              state_q    <= S_FETCH;
              illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: state_q <= (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ: begin
          if (mem_ready) state_q <= S_MEM_WB;
          else if (timeout_hit) begin
            state_q   <= S_FETCH;
            bus_error <= 1'b1;
          end else wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_MEM_WRITE: begin
          if (mem_ready) begin
            state_q     <= S_FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end else if (timeout_hit) begin
            state_q   <= S_FETCH;
            bus_error <= 1'b1;
          end else wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_EXECUTE:  state_q <= S_ALU_WB;
        S_IMM_EXEC: state_q <= S_IMM_WB;
        S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP: begin
          state_q     <= S_FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Moore control decode from the state register, forced low while in reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          alu_src_b = (opcode_q == OP_SHIFT) ? 2'b10 : 2'b00;
        end
        S_ALU_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = (opcode_q == OP_ANDI) ? 2'b11 : 2'b00;
        end
        S_IMM_WB: reg_write = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model expands each instruction
// into expected per-cycle outputs; a monitor compares them against the DUT every cycle.
module tb_multicycle_control;

  localparam int TMO   = 4;
  localparam int CNT_W = 2;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_READ = 3,
                 ST_MEM_WB = 4, ST_MEM_WRITE = 5, ST_EXECUTE = 6, ST_ALU_WB = 7,
                 ST_BRANCH = 8, ST_JUMP = 9, ST_IMM_EXEC = 10, ST_IMM_WB = 11;

  typedef struct packed {
    logic             mr;
    logic [5:0]       op;
    logic [3:0]       st;
    logic [15:0]      ctrl;
    logic             ill;
    logic             bus;
    logic [CNT_W-1:0] cnt;
  } step_t;

  logic clk = 1'b0;
  logic reset_n, mem_ready;
  logic [5:0] opcode;
  logic pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, bus_error;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;
  logic [15:0] act_ctrl;

  step_t stim_q[$];
  step_t sb_q[$];
  int n_cmp = 0, n_fail = 0;
  int m_count = 0;
  bit pend_ill = 0, pend_bus = 0;
  bit run = 0;
  logic [5:0] legal_ops [9] = '{6'o00, 6'o60, 6'o43, 6'o53, 6'o10, 6'o14, 6'o04, 6'o02, 6'o00};

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .bus_error(bus_error), .instr_count(instr_count)
  );

  assign act_ctrl = {pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Expected control word for a state, straight from the per-state output table.
  function automatic logic [15:0] exp_ctrl(int st, logic mr, logic [5:0] lop);
    logic pcw = 0, pcc = 0, iod = 0, irw = 0, mrd = 0, mwr = 0, m2r = 0, rdst = 0, rw = 0, sa = 0;
    logic [1:0] sb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (st)
      ST_FETCH:     begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE:    sb = 2'b11;
      ST_EXECUTE:   begin sa = 1; aop = 2'b10; sb = (lop == 6'o60) ? 2'b10 : 2'b00; end
      ST_ALU_WB:    begin rdst = 1; rw = 1; end
      ST_IMM_EXEC:  begin sa = 1; sb = 2'b10; aop = (lop == 6'o14) ? 2'b11 : 2'b00; end
      ST_IMM_WB:    rw = 1;
      ST_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      ST_MEM_READ:  begin mrd = 1; iod = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; end
      ST_MEM_WRITE: begin mwr = 1; iod = 1; end
      ST_BRANCH:    begin sa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
      ST_JUMP:      begin pcw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, iod, irw, mrd, mwr, m2r, rdst, rw, sa, sb, aop, psrc};
  endfunction

  function automatic void push_step(int st, logic mr, logic [5:0] dop, logic [5:0] lop);
    step_t s;
    s.mr   = mr;
    s.op   = dop;
    s.st   = 4'(st);
    s.ctrl = exp_ctrl(st, mr, lop);
    s.ill  = pend_ill;
    s.bus  = pend_bus;
    s.cnt  = CNT_W'(m_count);
    pend_ill = 0;
    pend_bus = 0;
    stim_q.push_back(s);
  endfunction

  // One instruction: wf fetch-wait cycles, wm memory-wait cycles; waits >= TMO time out.
  function automatic void gen_instr(logic [5:0] op, int wf, int wm);
    for (int i = 0; i < wf && i < TMO; i++) push_step(ST_FETCH, 1'b0, 6'($urandom), op);
    if (wf >= TMO) begin pend_bus = 1; return; end
    push_step(ST_FETCH, 1'b1, 6'($urandom), op);
    push_step(ST_DECODE, 1'($urandom), op, op);
    case (op)
      6'o00, 6'o60: begin
        push_step(ST_EXECUTE, 1'($urandom), 6'($urandom), op);
        push_step(ST_ALU_WB, 1'($urandom), 6'($urandom), op);
      end
      6'o10, 6'o14: begin
        push_step(ST_IMM_EXEC, 1'($urandom), 6'($urandom), op);
        push_step(ST_IMM_WB, 1'($urandom), 6'($urandom), op);
      end
      6'o43, 6'o53: begin
        int wst = (op == 6'o43) ? ST_MEM_READ : ST_MEM_WRITE;
        push_step(ST_MEM_ADDR, 1'($urandom), 6'($urandom), op);
        for (int i = 0; i < wm && i < TMO; i++) push_step(wst, 1'b0, 6'($urandom), op);
        if (wm >= TMO) begin pend_bus = 1; return; end
        push_step(wst, 1'b1, 6'($urandom), op);
        if (op == 6'o43) push_step(ST_MEM_WB, 1'($urandom), 6'($urandom), op);
      end
      6'o04: push_step(ST_BRANCH, 1'($urandom), 6'($urandom), op);
      6'o02: push_step(ST_JUMP, 1'($urandom), 6'($urandom), op);
      default: begin pend_ill = 1; return; end
    endcase
    m_count++;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
    return 0;
  endfunction

  // Driver: one step per cycle, expected response goes to the scoreboard.
  always @(posedge clk) begin
    step_t s;
    #1;
    if (run && stim_q.size() != 0) begin
      s = stim_q.pop_front();
      mem_ready = s.mr;
      opcode    = s.op;
      sb_q.push_back(s);
    end else begin
      mem_ready = 1'b0;
      opcode    = 6'd0;
    end
  end

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    step_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ctrl", 32'(act_ctrl), 32'(e.ctrl));
      check("illegal_op", 32'(illegal_op), 32'(e.ill));
      check("bus_error", 32'(bus_error), 32'(e.bus));
      check("instr_count", 32'(instr_count), 32'(e.cnt));
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_ctrl"}, 32'(act_ctrl), 32'd0);
    check({tag, "_count"}, 32'(instr_count), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    check({tag, "_bus"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    logic [5:0] op;
    int wf, wm;
    bit drained = 0;
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    gen_instr(6'o00, 0, 0);
    gen_instr(6'o43, 0, 3);
    gen_instr(6'o77, 0, 0);
    gen_instr(6'o53, 0, 4);
    gen_instr(6'o53, 0, 3);
    gen_instr(6'o04, 0, 0);
    gen_instr(6'o02, 0, 0);
    gen_instr(6'o60, 1, 0);
    gen_instr(6'o10, 2, 0);
    gen_instr(6'o14, 0, 0);
    gen_instr(6'o00, 5, 0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else op = legal_ops[$urandom_range(0, 7)];
      wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 0;
      gen_instr(op, wf, wm);
    end
    // Tail: stop inside MEM_ADDR of a lw, then reset mid-instruction.
    push_step(ST_FETCH, 1'b1, 6'o00, 6'o43);
    push_step(ST_DECODE, 1'b1, 6'o43, 6'o43);
    push_step(ST_MEM_ADDR, 1'b1, 6'o00, 6'o43);

    @(negedge clk);
    run = 1;
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 50000; i++) begin
      @(posedge clk);
      #2;
      if (stim_q.size() == 0) begin drained = 1; break; end
    end
    check("drain", 32'(drained), 32'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk);
    #1 check_reset_outputs("heldreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
